data_send: RTL and testbench
============================

Name: data_send

Overview:
- Packet-drain stage directly downstream of the packet builder.
- After the builder finishes, this block reads the assembled packet (INFO or DATA) from the 8-bit packet RAM read port.
- Emits the packet as a byte stream with valid/ready/last toward the USB/UDP transmit path.
- Packet length is derived from the same usb_stat device-status bits the builder used, so both blocks agree on frame size.

Parameters:
- RD_LAT, 2, packet-RAM read latency in clk cycles (address to data); legal values 1..3.
- FIFO_DEPTH, 4, output skid FIFO depth in bytes; must be ≥ RD_LAT+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fs  in  1  start; level, held high until fd is seen
- fd  out  1  done; high while in DONE
- btype  in  4  packet type; 0x1=INFO, 0xE=DATA, other=none
- data_idx  in  4  DATA slot 0..5
- usb_stat  in  80  [0:79]; device k status = bits [10k:10k+1]
- ram_txa  out  15  packet-RAM read address
- ram_txd  in  8  packet-RAM read data, valid RD_LAT cycles after address
- tx_data  out  8  stream byte
- tx_valid  out  1  byte valid
- tx_ready  in  1  sink accepts the byte when tx_valid&&tx_ready
- tx_last  out  1  high with the final byte of the packet
- tx_len  out  13  latched packet length in bytes

Behaviour:
- Reset values: ram_txa=0, tx_valid=0, tx_last=0, tx_len=0, fd=0, FIFO empty, all counters 0, state IDLE.
- States: IDLE→WAIT unconditionally.
- WAIT→LEN when fs=1.
- LEN: takes 1 cycle.
  - Latch base and len.
  - len=0 → DONE; otherwise → READ.
- READ→DRAIN once len addresses have been issued.
- DRAIN→DONE once len bytes have been handshaken out.
- DONE→WAIT when fs=0.
- Base and length decode in LEN:
  - btype=0x1: base=0x0100, len=14.
  - btype=0xE with data_idx 0..5: base=0x1000,0x2200,0x3400,0x4600,0x5800,0x6A00 respectively.
    - len = 8 + Σ dlen(k) over k=0..7.
    - dlen: 00→0, 01→128, 10→256, 11→512.
    - Maximum len is 4104; 13-bit unsigned arithmetic, no overflow.
  - btype=0xE with data_idx>5, or any other btype: len=0. Goes to DONE with no bytes, so the upstream never stalls.
- tx_len is loaded in LEN and held until the next LEN.
- Read issue:
  - In READ, issue one address per cycle only while (FIFO occupancy + reads in flight) < FIFO_DEPTH.
  - Addresses run base, base+1, …, base+len-1.
  - A RD_LAT-deep valid shift register tracks reads in flight; each returning byte is written into the FIFO.
- FIFO and output:
  - tx_data/tx_valid present the FIFO head.
  - Pop on tx_valid&&tx_ready.
  - Push and pop in the same cycle leave occupancy unchanged.
  - With tx_ready held at 1, throughput is 1 byte/clk after an initial RD_LAT+1 cycle latency from LEN exit.
- tx_last=1 exactly when tx_valid=1 and the head byte is packet byte len-1.
- Backpressure: while tx_ready=0, tx_data/tx_valid/tx_last stay stable. The FIFO is never overrun, because of the issue rule above.
- fs dropping mid-packet is ignored; the packet is completed.
- fs still high in DONE holds DONE (fd stays 1).
- Asynchronous reset mid-packet: return to IDLE, flush the FIFO and in-flight tracking, deassert tx_valid immediately. A partial packet is abandoned and no tx_last is emitted.
- ram_txa holds its last value when not issuing and returns to 0 in WAIT.

Test Plan:
- INFO packet:
  - Stimulus: RAM 0x0100..0x010D preloaded with 66 BB 00 1E …; fs=1, btype=1, tx_ready=1.
  - Required: 14 bytes in order, tx_last on the 14th, tx_len=14, fd rises after the last byte.
  - Required: fd falls one cycle after fs=0.
- DATA packet, slot 2:
  - Stimulus: usb_stat with dev0=01, dev3=11, rest 00; btype=0xE.
  - Required: tx_len=8+128+512=648; addresses 0x3400..0x3687 issued.
  - Required: bytes match RAM contents, tx_last on byte 648.
- Backpressure:
  - Stimulus: DATA slot 0, dev0=01; tx_ready toggles 1,0,0,1 repeatedly.
  - Required: no byte lost or duplicated.
  - Required: FIFO occupancy never exceeds 4.
  - Required: tx_data stays stable while stalled.
- Empty and illegal requests:
  - Stimulus: btype=0xE with all device status 00.
  - Required: 8 bytes (header + trigger), tx_len=8.
  - Stimulus: btype=0x0, and separately btype=0xE with data_idx=7.
  - Required: no tx_valid, fd asserted within 3 cycles of fs.
- Reset mid-packet:
  - Stimulus: assert rst at byte 100 of a 648-byte packet.
  - Required: tx_valid=0 in the same cycle, state IDLE.
  - Required: after a new fs, the next packet starts cleanly at its base address.
- Maximum length:
  - Stimulus: all devices 11, slot 5, tx_ready=1.
  - Required: tx_len=4104, final address 0x7A07.
  - Required: continuous 1 byte/clk after fill.

Source files
------------

// File: rtl/data_send.sv
// Packet drain: reads an INFO/DATA packet out of the packet RAM and streams it
// as bytes through a small skid FIFO with valid/ready/last.
module data_send #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fs_i,
  output logic          fd_o,
  input  logic [3:0]    btype_i,
  input  logic [3:0]    data_idx_i,
  input  logic [0:79]   usb_stat_i,
  output logic [14:0]   ram_txa_o,
  input  logic [7:0]    ram_txd_i,
  output logic [7:0]    tx_data_o,
  output logic          tx_valid_o,
  input  logic          tx_ready_i,
  output logic          tx_last_o,
  output logic [12:0]   tx_len_o,
  output logic [2:0]    state_o,
  output logic [CW-1:0] fifo_cnt_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LEN   = 3'd2,
    S_READ  = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [14:0]   base_q, ram_txa_q, dec_base;
  logic [12:0]   len_q, rd_cnt_q, tx_cnt_q, dec_len;
  logic [RD_LAT:0] vld_q;
  logic [7:0]    fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]    inflight, used;
  logic          issue, push, pop;
  logic          unused_stat;

  // Only the two code bits of each 10-bit device field matter here.
  assign unused_stat = ^usb_stat_i;

  always_comb begin
    dec_base = '0;
    dec_len  = '0;
    if (btype_i == 4'h1) begin
      dec_base = 15'h0100;
      dec_len  = 13'd14;
    end else if (btype_i == 4'hE && data_idx_i <= 4'd5) begin
      dec_base = 15'h1000 + 15'(data_idx_i) * 15'h1200;
      dec_len  = 13'd8;
      for (int k = 0; k < 8; k++) begin
        case ({usb_stat_i[10*k], usb_stat_i[10*k+1]})
          2'b01:   dec_len = dec_len + 13'd128;
          2'b10:   dec_len = dec_len + 13'd256;
          2'b11:   dec_len = dec_len + 13'd512;
          default: dec_len = dec_len;
        endcase
      end
    end
  end

  // Handshake: a byte transfers on a cycle where tx_valid_o && tx_ready_i;
  // while tx_ready_i is low the presented byte, valid and last hold steady.
  assign tx_valid_o = (cnt_q != '0);
  assign tx_data_o  = fifo_mem_q[rd_ptr_q];
  assign tx_last_o  = tx_valid_o && (tx_cnt_q == len_q - 13'd1);
  assign pop        = tx_valid_o && tx_ready_i;
  assign push       = vld_q[RD_LAT];

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + 8'(vld_q[i]);
  end

  // A slot released by this cycle's pop may be claimed by this cycle's issue.
  assign used = 8'(cnt_q) + inflight - 8'(pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_WAIT;
      S_WAIT:  if (fs_i) state_d = S_LEN;
      S_LEN:   state_d = (dec_len == '0) ? S_DONE : S_READ;
      S_READ:  if (issue && rd_cnt_q == len_q - 13'd1) state_d = S_DRAIN;
      S_DRAIN: if (pop && tx_cnt_q == len_q - 13'd1) state_d = S_DONE;
      S_DONE:  if (!fs_i) state_d = S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fd_o    = (state_q == S_DONE);
    issue   = (state_q == S_READ) && (rd_cnt_q != len_q) && (used < 8'(FIFO_DEPTH));
    state_o = state_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q    <= '0;
      len_q     <= '0;
      rd_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      ram_txa_q <= '0;
      vld_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      vld_q <= {vld_q[RD_LAT-1:0], issue};
      if (state_q == S_LEN) begin
        base_q   <= dec_base;
        len_q    <= dec_len;
        rd_cnt_q <= '0;
        tx_cnt_q <= '0;
      end else begin
        if (issue) rd_cnt_q <= rd_cnt_q + 13'd1;
        if (pop)   tx_cnt_q <= tx_cnt_q + 13'd1;
      end
      if (issue)                 ram_txa_q <= base_q + 15'(rd_cnt_q);
      else if (state_q == S_WAIT) ram_txa_q <= '0;
      if (push) wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= ram_txd_i;
  end

  assign ram_txa_o  = ram_txa_q;
  assign tx_len_o   = len_q;
  assign fifo_cnt_o = cnt_q;

endmodule

// File: tb/tb_data_send.sv
// Bench for data_send: packet RAM model with read latency, byte scoreboard
// fed from a length/base model, backpressure and reset scenarios.
module tb_data_send;

  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [3:0]  btype;
  logic [3:0]  data_idx;
  logic [0:79] usb_stat;
  logic [14:0] ram_txa;
  logic [7:0]  ram_txd;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        tx_last;
  logic [12:0] tx_len;
  logic [2:0]  state;
  logic [2:0]  fifo_cnt;

  data_send #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .fs_i(fs), .fd_o(fd), .btype_i(btype),
    .data_idx_i(data_idx), .usb_stat_i(usb_stat), .ram_txa_o(ram_txa),
    .ram_txd_i(ram_txd), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .tx_last_o(tx_last), .tx_len_o(tx_len),
    .state_o(state), .fifo_cnt_o(fifo_cnt)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // packet RAM with RD_LAT cycles from address to data
  logic [7:0] mem [0:32767];
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem[ram_txa];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_txd = rd_pipe[RD_LAT-1];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model
  logic [7:0]  exp_q[$];
  logic [1:0]  dev_code [8];
  int          dlen_tab [4]  = '{0, 128, 256, 512};
  int          slot_base [6] = '{'h1000, 'h2200, 'h3400, 'h4600, 'h5800, 'h6A00};

  function automatic int model_len(input logic [3:0] bt, input logic [3:0] idx);
    int l;
    if (bt == 4'h1) return 14;
    if (bt != 4'hE || idx > 4'd5) return 0;
    l = 8;
    for (int k = 0; k < 8; k++) l += dlen_tab[dev_code[k]];
    return l;
  endfunction

  function automatic int model_base(input logic [3:0] bt, input logic [3:0] idx);
    if (bt == 4'h1) return 'h0100;
    if (bt == 4'hE && idx <= 4'd5) return slot_base[idx];
    return 0;
  endfunction

  task automatic set_stat();
    for (int b = 0; b < 80; b++) usb_stat[b] = 1'($urandom_range(0, 1));
    for (int k = 0; k < 8; k++) begin
      usb_stat[10*k]   = dev_code[k][1];
      usb_stat[10*k+1] = dev_code[k][0];
    end
  endtask

  task automatic set_codes(input logic [1:0] c);
    for (int k = 0; k < 8; k++) dev_code[k] = c;
  endtask

  // sink ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random
  int         ready_mode = 0;
  int         ph = 0;
  logic [3:0] ready_pat = 4'b1001;
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: begin tx_ready = ready_pat[ph]; ph = (ph + 1) % 4; end
        default: tx_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // scoreboard / monitor
  int         cyc_cnt = 0;
  int         hs_cnt = 0;
  int         first_hs = 0;
  int         last_hs = 0;
  int         valid_cycles = 0;
  int         max_occ = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic       prev_last = 1'b0;
  logic [7:0] exp_b;

  initial begin
    forever begin
      @(negedge clk);
      cyc_cnt++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (int'(fifo_cnt) > max_occ) max_occ = int'(fifo_cnt);
        if (prev_stall) begin
          check_eq("stall_valid", tx_valid, 1);
          check_eq("stall_data", tx_data, prev_data);
          check_eq("stall_last", tx_last, prev_last);
        end
        if (tx_valid) valid_cycles++;
        if (tx_valid && tx_ready) begin
          if (hs_cnt == 0) first_hs = cyc_cnt;
          last_hs = cyc_cnt;
          hs_cnt++;
          check_eq("byte_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            check_eq("data", tx_data, exp_b);
            check_eq("last", tx_last, 32'(exp_q.size() == 0));
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_last  = tx_last;
      end
    end
  end

  task automatic run_packet(input logic [3:0] bt, input logic [3:0] idx, input int mode,
                            input bit drop_fs, input string tag);
    int l, b, cyc;
    l = model_len(bt, idx);
    b = model_base(bt, idx);
    exp_q.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(mem[b + i]);
    ready_mode = mode;
    hs_cnt = 0; valid_cycles = 0; max_occ = 0;
    set_stat();
    btype = bt;
    data_idx = idx;
    @(negedge clk);
    fs = 1'b1;
    cyc = 0;
    while (!fd && cyc < l * 4 + 50) begin
      @(negedge clk);
      #1;
      cyc++;
      if (drop_fs && cyc == 5) fs = 1'b0;
    end
    check_eq({tag, "_fd_seen"}, fd, 1);
    check_eq({tag, "_len"}, tx_len, l);
    check_eq({tag, "_bytes_left"}, exp_q.size(), 0);
    check_eq({tag, "_bytes_sent"}, hs_cnt, l);
    if (l > 0) check_eq({tag, "_last_addr"}, ram_txa, b + l - 1);
    else begin
      check_eq({tag, "_no_valid"}, valid_cycles, 0);
      check_eq({tag, "_fd_latency"}, 32'(cyc <= 3), 1);
    end
    if (mode == 0 && l > 0) check_eq({tag, "_throughput"}, last_hs - first_hs, l - 1);
    check_eq({tag, "_max_occ"}, 32'(max_occ <= FIFO_DEPTH), 1);
    if (fs) begin
      repeat (2) @(negedge clk);
      check_eq({tag, "_fd_hold"}, fd, 1);
    end
    fs = 1'b0;
    @(negedge clk);
    check_eq({tag, "_fd_fall"}, fd, 0);
    @(negedge clk);
    check_eq({tag, "_txa_wait"}, ram_txa, 0);
  endtask

  task automatic reset_mid_packet();
    int l, b, cyc;
    set_codes(2'b00);
    dev_code[0] = 2'b01;
    dev_code[3] = 2'b11;
    l = model_len(4'hE, 4'd2);
    b = model_base(4'hE, 4'd2);
    exp_q.delete();
    for (int i = 0; i < l; i++) exp_q.push_back(mem[b + i]);
    ready_mode = 0;
    hs_cnt = 0;
    set_stat();
    btype = 4'hE;
    data_idx = 4'd2;
    @(negedge clk);
    fs = 1'b1;
    cyc = 0;
    while (hs_cnt < 100 && cyc < 1000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq("rst_reached_byte100", hs_cnt, 100);
    check_eq("rst_valid_before", tx_valid, 1);
    rst = 1'b1;
    #1;
    check_eq("rst_valid_now", tx_valid, 0);
    check_eq("rst_last_now", tx_last, 0);
    check_eq("rst_state", state, 0);
    check_eq("rst_fifo", fifo_cnt, 0);
    check_eq("rst_len", tx_len, 0);
    fs = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_packet(4'hE, 4'd2, 0, 1'b0, "after_rst");
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog got=timeout exp=finish");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
    mem['h0100] = 8'h66;
    mem['h0101] = 8'hBB;
    mem['h0102] = 8'h00;
    mem['h0103] = 8'h1E;
    rst = 1'b1;
    fs = 1'b0;
    btype = '0;
    data_idx = '0;
    usb_stat = '0;
    set_codes(2'b00);
    #3;
    check_eq("reset_valid", tx_valid, 0);
    check_eq("reset_last", tx_last, 0);
    check_eq("reset_len", tx_len, 0);
    check_eq("reset_fd", fd, 0);
    check_eq("reset_txa", ram_txa, 0);
    check_eq("reset_state", state, 0);
    check_eq("reset_fifo", fifo_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_packet(4'h1, 4'd0, 0, 1'b0, "info");

    set_codes(2'b00);
    dev_code[0] = 2'b01;
    dev_code[3] = 2'b11;
    run_packet(4'hE, 4'd2, 0, 1'b0, "slot2");

    set_codes(2'b00);
    dev_code[0] = 2'b01;
    run_packet(4'hE, 4'd0, 1, 1'b0, "backpressure");

    set_codes(2'b00);
    run_packet(4'hE, 4'd3, 0, 1'b0, "empty");
    run_packet(4'h0, 4'd1, 0, 1'b0, "btype0");
    run_packet(4'hE, 4'd7, 0, 1'b0, "idx7");

    reset_mid_packet();

    set_codes(2'b11);
    run_packet(4'hE, 4'd5, 0, 1'b0, "max");

    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++)
        dev_code[k] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_packet(($urandom_range(0, 3) == 0) ? 4'h1 : 4'hE, 4'($urandom_range(0, 7)),
                 2, 1'(r % 2), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
